// File: rtl/sha2_core_mb.sv
// sha2_core_mb: multi-block SHA-2 compression core (SHA-224/256/384/512 and SHA-512/t).
// Absorbs a 16-word block, runs NR rounds one per cycle and folds the result into H.
module sha2_core_mb #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned MODE        = 512,
    parameter int unsigned T           = 0,
    parameter int unsigned OUTPUT_SIZE = (T == 0) ? MODE : T
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       data_in,
    output logic                   busy,
    output logic                   done,
    output logic [8*WIDTH-1:0]     H_out,
    output logic [OUTPUT_SIZE-1:0] digest
);
    localparam int unsigned NR = (WIDTH == 32) ? 64 : 80;
    localparam int unsigned CW = 7;

    // Initial hash value; 32-bit variants live in the low 256 bits before truncation.
    function automatic logic [8*WIDTH-1:0] iv_of();
        logic [511:0] v;
        case (MODE)
            224: v = 512'(256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4);
            256: v = 512'(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);
            384: v = {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                      64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
            default: begin
                if (T == 224)
                    v = {64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
                         64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1};
                else if (T == 256)
                    v = {64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
                         64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2};
                else
                    v = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                         64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
            end
        endcase
        return (8*WIDTH)'(v);
    endfunction

    localparam logic [8*WIDTH-1:0] IV = iv_of();

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction

    function automatic logic [WIDTH-1:0] bsig0(input logic [WIDTH-1:0] x);
        if (WIDTH == 32) return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
        else             return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
    endfunction

    function automatic logic [WIDTH-1:0] bsig1(input logic [WIDTH-1:0] x);
        if (WIDTH == 32) return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
        else             return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
    endfunction

    function automatic logic [WIDTH-1:0] ssig0(input logic [WIDTH-1:0] x);
        if (WIDTH == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
        else             return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [WIDTH-1:0] ssig1(input logic [WIDTH-1:0] x);
        if (WIDTH == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
        else             return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

    state_t                 state;
    logic [3:0]             wcnt;
    logic [CW-1:0]          rcnt;
    logic                   ready_q;
    logic [0:7][WIDTH-1:0]  hv;
    logic [0:7][WIDTH-1:0]  wv;
    logic [WIDTH-1:0]       w [16];
    logic [WIDTH-1:0]       k_q;
    logic [CW-1:0]          k_addr;
    logic [WIDTH-1:0]       t1;
    logic [WIDTH-1:0]       t2;
    logic [WIDTH-1:0]       w_new;
    logic                   accept;

    assign in_ready = ready_q && !init;
    assign accept   = in_ready && in_valid;
    assign H_out    = hv;
    assign digest   = H_out[8*WIDTH-1 -: OUTPUT_SIZE];

    // Round function and next schedule word; w[0] always holds W_t of the current round.
    always_comb begin
        t1    = wv[7] + bsig1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + k_q + w[0];
        t2    = bsig0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
        w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    end

    // K address runs one round ahead of the registered ROM output.
    always_comb begin
        k_addr = '0;
        if (state == S_ROUND && rcnt != CW'(NR - 1))
            k_addr = rcnt + CW'(1);
    end

    if (WIDTH == 32) begin : g_k256
        localparam logic [31:0] K256 [64] = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
        logic unused_addr_msb;
        assign unused_addr_msb = k_addr[6];
        always_ff @(posedge clk) k_q <= K256[k_addr[5:0]];
    end else begin : g_k512
        localparam logic [63:0] K512 [80] = '{
            64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
            64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
            64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
            64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
            64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
            64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
            64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
            64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
            64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
            64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
            64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
            64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
            64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
            64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
            64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
            64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
            64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
            64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
            64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
            64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
        };
        always_ff @(posedge clk) k_q <= K512[k_addr];
    end

    // Message schedule and working variables; no reset needed, reloaded by every block.
    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            if (accept) begin
                w[wcnt] <= data_in;
                if (wcnt == 4'd0)
                    wv <= hv;
            end
        end else if (state == S_ROUND) begin
            for (int i = 0; i < 15; i++)
                w[i] <= w[i+1];
            w[15] <= w_new;
            wv    <= {t1 + t2, wv[0], wv[1], wv[2], wv[3] + t1, wv[4], wv[5], wv[6]};
        end
    end

    // Control FSM and chaining value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            rcnt    <= '0;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            hv      <= IV;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (init) begin
                        hv <= IV;
                    end else if (accept) begin
                        wcnt <= wcnt + 4'd1;
                        if (wcnt == 4'd15) begin
                            state   <= S_ROUND;
                            rcnt    <= '0;
                            ready_q <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_ROUND: begin
                    rcnt <= rcnt + CW'(1);
                    if (rcnt == CW'(NR - 1))
                        state <= S_FINAL;
                end
                S_FINAL: begin
                    for (int i = 0; i < 8; i++)
                        hv[i] <= hv[i] + wv[i];
                    state   <= S_IDLE;
                    rcnt    <= '0;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
